// File: rtl/npc_mem_pkg.sv
// Shared encodings for the core memory-port arbiter: FSM states, owner ids
// and the default response watchdog limit.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin grant between fetch and load/store. On a tie the
// requester that did not own the previous transaction wins.
module mem_rr_pick
    import npc_mem_pkg::*;
(
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
    input  logic last_owner_i,
    output logic gnt_ifu_o,
    output logic gnt_lsu_o
);

    assign gnt_ifu_o = ifu_valid_i && (!lsu_valid_i || (last_owner_i == OWN_LSU));
    assign gnt_lsu_o = lsu_valid_i && (!ifu_valid_i || (last_owner_i == OWN_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the core memory port between fetch and load/store, one transaction
// in flight at a time, with a watchdog that turns a hung response into an error.
module mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int               MASK_W  = DATA_W / 8;
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                resp_vld_q, resp_vld_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt_ifu, gnt_lsu;

    mem_rr_pick u_pick (
        .ifu_valid_i  (ifu_req_valid),
        .lsu_valid_i  (lsu_req_valid),
        .last_owner_i (last_q),
        .gnt_ifu_o    (gnt_ifu),
        .gnt_lsu_o    (gnt_lsu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IFU;
            last_q     <= OWN_LSU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
            resp_vld_q <= 1'b0;
            resp_err_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
            resp_vld_q <= resp_vld_d;
            resp_err_q <= resp_err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        cnt_d         = cnt_q;
        resp_vld_d    = 1'b0;
        resp_err_d    = 1'b0;
        rdata_d       = '0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so it drops asynchronously too.
                ifu_req_ready = gnt_ifu && !rst;
                lsu_req_ready = gnt_lsu && !rst;
                if (gnt_ifu || gnt_lsu) begin
                    state_d = REQ;
                    owner_d = gnt_lsu ? OWN_LSU : OWN_IFU;
                    last_d  = gnt_lsu ? OWN_LSU : OWN_IFU;
                    addr_d  = gnt_lsu ? lsu_addr : ifu_addr;
                    wen_d   = gnt_lsu && lsu_wen;
                    wdata_d = gnt_lsu ? lsu_wdata : '0;
                    wmask_d = gnt_lsu ? lsu_wmask : '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // A response arriving on the timeout cycle still wins.
                if (mem_resp_valid) begin
                    state_d    = IDLE;
                    resp_vld_d = 1'b1;
                    rdata_d    = wen_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = IDLE;
                    resp_vld_d = 1'b1;
                    resp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_valid  = (state_q == REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    assign ifu_resp_valid = resp_vld_q && (owner_q == OWN_IFU);
    assign ifu_resp_err   = resp_err_q && (owner_q == OWN_IFU);
    assign ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
    assign lsu_resp_valid = resp_vld_q && (owner_q == OWN_LSU);
    assign lsu_resp_err   = resp_err_q && (owner_q == OWN_LSU);
    assign lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;

endmodule
